// File: rtl/spi_slave.sv
// SPI slave with selectable CPOL/CPHA, synchronized pin sampling on clk_i,
// a single-entry transmit holding buffer and streaming back-to-back words.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sck_i,
  input  logic             ss_n_i,
  input  logic             mosi_i,
  output logic             miso_o,
  output logic             miso_oe_o,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             tx_underrun_o,
  output logic             frame_err_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  // Synchronizer chains and one-cycle history for edge detection
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_p1, r_sck_p2;
  logic                   r_ss_p1, r_ss_p2;
  logic                   r_mosi_p1;

  // Control state
  state_t                 r_state;
  logic                   r_cpol, r_cpha;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_first;
  logic                   r_pend_ur;
  logic                   r_miso;
  logic                   r_buf_full;
  logic                   r_rx_valid;
  logic                   r_underrun;
  logic                   r_frame_err;

  // Datapath
  logic [WIDTH-1:0]       r_buf;
  logic [WIDTH-1:0]       r_shift;
  logic [WIDTH-1:0]       r_rx_shift;
  logic [WIDTH-1:0]       r_rx_data;

  logic                   w_sck_rise, w_sck_fall;
  logic                   w_ss_fall, w_ss_rise;
  logic                   w_lead, w_trail;
  logic                   w_sample, w_drive;
  logic                   w_wrap, w_load, w_wr;
  logic [WIDTH-1:0]       w_load_word;
  logic [WIDTH-1:0]       w_rx_next;

  // Bring the asynchronous pins into clk_i and keep one cycle of history
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_p1    <= 1'b0;
      r_sck_p2    <= 1'b0;
      r_ss_p1     <= 1'b1;
      r_ss_p2     <= 1'b1;
      r_mosi_p1   <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
      // ---- stage p1: synchronized pin values ----
      r_sck_p1    <= r_sck_sync[SYNC_STAGES-1];
      r_ss_p1     <= r_ss_sync[SYNC_STAGES-1];
      r_mosi_p1   <= r_mosi_sync[SYNC_STAGES-1];
      // ---- stage p2: previous value, used to find edges ----
      r_sck_p2    <= r_sck_p1;
      r_ss_p2     <= r_ss_p1;
    end
  end

  assign w_sck_rise = r_sck_p1 & ~r_sck_p2;
  assign w_sck_fall = ~r_sck_p1 & r_sck_p2;
  assign w_ss_fall  = ~r_ss_p1 & r_ss_p2;
  assign w_ss_rise  = r_ss_p1 & ~r_ss_p2;

  // Mode decode uses the CPOL/CPHA captured at the start of the frame
  assign w_lead   = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail  = r_cpol ? w_sck_rise : w_sck_fall;
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_drive  = r_cpha ? w_lead : w_trail;

  assign w_rx_next   = {r_rx_shift[WIDTH-2:0], r_mosi_p1};
  assign w_wrap      = (r_state == SHIFT) && !w_ss_rise && w_sample && (r_cnt == LAST_BIT);
  assign w_load      = (r_state == LOAD) || w_wrap;
  assign w_wr        = tx_valid_i && !r_buf_full;
  assign w_load_word = r_buf_full ? r_buf : '1;

  // Holding-buffer occupancy: a write wins over a same-cycle load, which
  // has already taken the old content (or the underrun pattern)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_buf_full <= 1'b0;
    end else if (w_wr) begin
      r_buf_full <= 1'b1;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
    end
  end

  // Holding-buffer data capture
  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_buf <= tx_data_i;
    end
  end

  // Frame FSM together with the shift datapath and status pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_cnt       <= '0;
      r_first     <= 1'b0;
      r_pend_ur   <= 1'b0;
      r_miso      <= 1'b1;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_miso <= 1'b1;
          r_cnt  <= '0;
          if (w_ss_fall) begin
            r_cpol  <= cpol_i;
            r_cpha  <= cpha_i;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // First word of the frame: an empty buffer is reported at once
          r_shift    <= w_load_word;
          r_first    <= 1'b1;
          r_pend_ur  <= 1'b0;
          r_underrun <= !r_buf_full;
          r_miso     <= r_cpha ? 1'b1 : w_load_word[WIDTH-1];
          r_cnt      <= '0;
          r_state    <= SHIFT;
        end
        SHIFT: begin
          if (w_ss_rise) begin
            r_state     <= IDLE;
            r_miso      <= 1'b1;
            r_cnt       <= '0;
            r_pend_ur   <= 1'b0;
            r_frame_err <= (r_cnt != '0);
          end else if (w_sample) begin
            r_rx_shift <= w_rx_next;
            r_first    <= 1'b0;
            // A word reloaded at a wrap only counts as underrun once the
            // master actually clocks it, not when the frame simply ends
            if (r_first && r_pend_ur) begin
              r_underrun <= 1'b1;
              r_pend_ur  <= 1'b0;
            end
            if (r_cnt == LAST_BIT) begin
              r_cnt      <= '0;
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
              r_shift    <= w_load_word;
              r_first    <= 1'b1;
              r_pend_ur  <= !r_buf_full;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (w_drive) begin
            // Drive edges ahead of a word's first sample present its MSB
            if (r_first) begin
              r_miso <= r_shift[WIDTH-1];
            end else begin
              r_shift <= {r_shift[WIDTH-2:0], 1'b1};
              r_miso  <= r_shift[WIDTH-2];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign miso_o        = r_miso;
  assign miso_oe_o     = (r_state != IDLE);
  assign tx_ready_o    = ~r_buf_full;
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = r_rx_valid;
  assign tx_underrun_o = r_underrun;
  assign frame_err_o   = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives frames in
// all four modes and the received/transmitted words are compared with
// hand-computed values.
module tb_spi_slave;

  localparam int HP = 8;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso_o, miso_oe_o;
  logic       m_cpol = 1'b0, m_cpha = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, tx_underrun_o, frame_err_o;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int last_lat = 0;
  int rxv_cnt = 0;
  int ur_cnt = 0;
  int fe_cnt = 0;

  logic [7:0] m_tx [4];
  logic [7:0] m_rx [4];

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ss_n_i(ss_n), .mosi_i(mosi),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o), .cpol_i(m_cpol), .cpha_i(m_cpha),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .tx_underrun_o(tx_underrun_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  // pulse counters, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rx_valid_o) begin
      rxv_cnt = rxv_cnt + 1;
      last_lat = cyc - edge_cyc;
    end
    if (tx_underrun_o) ur_cnt = ur_cnt + 1;
    if (frame_err_o) fe_cnt = fe_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_mode(input logic cpol, input logic cpha);
    m_cpol = cpol;
    m_cpha = cpha;
    sck = cpol;
    repeat (8) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    bit seen;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_ready_o) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL write_tx_timeout: tx_ready_o=%b required 1", tx_ready_o);
    end else begin
      tx_data = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  // Master: drives nbits bits from m_tx[], collects miso into m_rx[]
  task automatic master_frame(input int nbits, input bit raise_ss);
    for (int w = 0; w < 4; w++) m_rx[w] = 8'h00;
    ss_n = 1'b0;
    repeat (2*HP) @(negedge clk);
    for (int n = 0; n < nbits; n++) begin
      int w;
      int i;
      w = n / 8;
      i = 7 - (n % 8);
      if (!m_cpha) begin
        mosi = m_tx[w][i];
        repeat (HP) @(negedge clk);
        sck = ~sck;
        edge_cyc = cyc;
        m_rx[w][i] = miso_o;
        repeat (HP) @(negedge clk);
        sck = ~sck;
      end else begin
        sck = ~sck;
        mosi = m_tx[w][i];
        repeat (HP) @(negedge clk);
        sck = ~sck;
        edge_cyc = cyc;
        m_rx[w][i] = miso_o;
        repeat (HP) @(negedge clk);
      end
    end
    repeat (HP) @(negedge clk);
    if (raise_ss) begin
      ss_n = 1'b1;
      repeat (2*HP) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests_run++; if (miso_o !== 1'b1) begin tests_failed++; $display("FAIL reset_miso: got %b required 1", miso_o); end
    tests_run++; if (miso_oe_o !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b required 0", miso_oe_o); end
    tests_run++; if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b required 1", tx_ready_o); end
    tests_run++; if (rx_data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %h required 00", rx_data_o); end
    tests_run++; if (rx_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid_o); end
    tests_run++; if (tx_underrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_underrun: got %b required 0", tx_underrun_o); end
    tests_run++; if (frame_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b required 0", frame_err_o); end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_mode0;
    int rv0, ur0;
    set_mode(1'b0, 1'b0);
    write_tx(8'hA5);
    tests_run++; if (tx_ready_o !== 1'b0) begin tests_failed++; $display("FAIL mode0_ready_full: got %b required 0", tx_ready_o); end
    rv0 = rxv_cnt; ur0 = ur_cnt;
    m_tx[0] = 8'h3C;
    master_frame(8, 1'b1);
    tests_run++; if (m_rx[0] !== 8'hA5) begin tests_failed++; $display("FAIL mode0_miso: got %h required a5", m_rx[0]); end
    tests_run++; if (rx_data_o !== 8'h3C) begin tests_failed++; $display("FAIL mode0_rx_data: got %h required 3c", rx_data_o); end
    tests_run++; if (rxv_cnt - rv0 !== 1) begin tests_failed++; $display("FAIL mode0_rx_pulses: got %0d required 1", rxv_cnt - rv0); end
    tests_run++; if (last_lat !== 4) begin tests_failed++; $display("FAIL mode0_rx_latency: got %0d required 4", last_lat); end
    tests_run++; if (ur_cnt - ur0 !== 0) begin tests_failed++; $display("FAIL mode0_underrun: got %0d required 0", ur_cnt - ur0); end
    tests_run++; if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL mode0_ready_after: got %b required 1", tx_ready_o); end
  endtask

  task automatic test_modes;
    for (int m = 1; m <= 3; m++) begin
      int rv0;
      logic [1:0] mb;
      mb = 2'(m);
      set_mode(mb[1], mb[0]);
      write_tx(8'h81);
      rv0 = rxv_cnt;
      m_tx[0] = 8'h7E;
      master_frame(8, 1'b1);
      tests_run++; if (m_rx[0] !== 8'h81) begin tests_failed++; $display("FAIL mode%0d_miso: got %h required 81", m, m_rx[0]); end
      tests_run++; if (rx_data_o !== 8'h7E) begin tests_failed++; $display("FAIL mode%0d_rx_data: got %h required 7e", m, rx_data_o); end
      tests_run++; if (rxv_cnt - rv0 !== 1) begin tests_failed++; $display("FAIL mode%0d_rx_pulses: got %0d required 1", m, rxv_cnt - rv0); end
    end
  endtask

  task automatic test_back_to_back;
    int rv0, ur0;
    set_mode(1'b0, 1'b0);
    write_tx(8'h11);
    rv0 = rxv_cnt; ur0 = ur_cnt;
    m_tx[0] = 8'hC3; m_tx[1] = 8'h5A; m_tx[2] = 8'h0F;
    fork
      master_frame(24, 1'b1);
      write_tx(8'h22);
    join
    tests_run++; if (m_rx[0] !== 8'h11) begin tests_failed++; $display("FAIL b2b_word0: got %h required 11", m_rx[0]); end
    tests_run++; if (m_rx[1] !== 8'h22) begin tests_failed++; $display("FAIL b2b_word1: got %h required 22", m_rx[1]); end
    tests_run++; if (m_rx[2] !== 8'hFF) begin tests_failed++; $display("FAIL b2b_word2: got %h required ff", m_rx[2]); end
    tests_run++; if (ur_cnt - ur0 !== 1) begin tests_failed++; $display("FAIL b2b_underrun: got %0d required 1", ur_cnt - ur0); end
    tests_run++; if (rxv_cnt - rv0 !== 3) begin tests_failed++; $display("FAIL b2b_rx_pulses: got %0d required 3", rxv_cnt - rv0); end
    tests_run++; if (rx_data_o !== 8'h0F) begin tests_failed++; $display("FAIL b2b_rx_data: got %h required 0f", rx_data_o); end
  endtask

  task automatic test_frame_err;
    int rv0, fe0;
    set_mode(1'b0, 1'b0);
    write_tx(8'h96);
    rv0 = rxv_cnt; fe0 = fe_cnt;
    m_tx[0] = 8'hE1;
    master_frame(5, 1'b1);
    tests_run++; if (fe_cnt - fe0 !== 1) begin tests_failed++; $display("FAIL abort_frame_err: got %0d required 1", fe_cnt - fe0); end
    tests_run++; if (rxv_cnt - rv0 !== 0) begin tests_failed++; $display("FAIL abort_rx_pulses: got %0d required 0", rxv_cnt - rv0); end
    tests_run++; if (rx_data_o !== 8'h0F) begin tests_failed++; $display("FAIL abort_rx_hold: got %h required 0f", rx_data_o); end
    write_tx(8'h3A);
    rv0 = rxv_cnt; fe0 = fe_cnt;
    m_tx[0] = 8'h55;
    master_frame(8, 1'b1);
    tests_run++; if (rx_data_o !== 8'h55) begin tests_failed++; $display("FAIL after_abort_rx_data: got %h required 55", rx_data_o); end
    tests_run++; if (m_rx[0] !== 8'h3A) begin tests_failed++; $display("FAIL after_abort_miso: got %h required 3a", m_rx[0]); end
    tests_run++; if (rxv_cnt - rv0 !== 1) begin tests_failed++; $display("FAIL after_abort_rx_pulses: got %0d required 1", rxv_cnt - rv0); end
    tests_run++; if (fe_cnt - fe0 !== 0) begin tests_failed++; $display("FAIL after_abort_frame_err: got %0d required 0", fe_cnt - fe0); end
  endtask

  task automatic test_reset_midword;
    int fe0;
    set_mode(1'b0, 1'b0);
    write_tx(8'hE7);
    fe0 = fe_cnt;
    m_tx[0] = 8'hC0;
    master_frame(3, 1'b0);
    write_tx(8'h5B);
    tests_run++; if (tx_ready_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_ready_before: got %b required 0", tx_ready_o); end
    tests_run++; if (miso_oe_o !== 1'b1) begin tests_failed++; $display("FAIL midrst_oe_before: got %b required 1", miso_oe_o); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++; if (miso_o !== 1'b1) begin tests_failed++; $display("FAIL midrst_miso: got %b required 1", miso_o); end
    tests_run++; if (miso_oe_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_oe: got %b required 0", miso_oe_o); end
    tests_run++; if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready: got %b required 1", tx_ready_o); end
    tests_run++; if (rx_data_o !== 8'h00) begin tests_failed++; $display("FAIL midrst_rx_data: got %h required 00", rx_data_o); end
    tests_run++; if ({rx_valid_o, tx_underrun_o, frame_err_o} !== 3'b000) begin tests_failed++; $display("FAIL midrst_pulses: got %b required 000", {rx_valid_o, tx_underrun_o, frame_err_o}); end
    @(negedge clk);
    ss_n = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    tests_run++; if (fe_cnt - fe0 !== 0) begin tests_failed++; $display("FAIL midrst_frame_err: got %0d required 0", fe_cnt - fe0); end
    write_tx(8'h69);
    m_tx[0] = 8'h96;
    master_frame(8, 1'b1);
    tests_run++; if (m_rx[0] !== 8'h69) begin tests_failed++; $display("FAIL midrst_next_miso: got %h required 69", m_rx[0]); end
    tests_run++; if (rx_data_o !== 8'h96) begin tests_failed++; $display("FAIL midrst_next_rx_data: got %h required 96", rx_data_o); end
  endtask

  task automatic test_load_write;
    int ur0;
    set_mode(1'b0, 1'b0);
    tests_run++; if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL lw_buffer_empty: got %b required 1", tx_ready_o); end
    ur0 = ur_cnt;
    m_tx[0] = 8'h12; m_tx[1] = 8'h34;
    fork
      master_frame(16, 1'b1);
      begin
        bit seen;
        seen = 0;
        for (int k = 0; k < 200; k++) begin
          @(posedge clk);
          #1;
          if (miso_oe_o) begin
            seen = 1;
            break;
          end
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL lw_select_timeout: miso_oe_o=%b required 1", miso_oe_o); end
        tests_run++; if (tx_ready_o !== 1'b1) begin tests_failed++; $display("FAIL lw_ready_in_load: got %b required 1", tx_ready_o); end
        tx_data = 8'hC6;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tests_run++; if (tx_ready_o !== 1'b0) begin tests_failed++; $display("FAIL lw_ready_after_write: got %b required 0", tx_ready_o); end
      end
    join
    tests_run++; if (m_rx[0] !== 8'hFF) begin tests_failed++; $display("FAIL lw_word0: got %h required ff", m_rx[0]); end
    tests_run++; if (m_rx[1] !== 8'hC6) begin tests_failed++; $display("FAIL lw_word1: got %h required c6", m_rx[1]); end
    tests_run++; if (ur_cnt - ur0 !== 1) begin tests_failed++; $display("FAIL lw_underrun: got %0d required 1", ur_cnt - ur0); end
    tests_run++; if (rx_data_o !== 8'h34) begin tests_failed++; $display("FAIL lw_rx_data: got %h required 34", rx_data_o); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_frame_err();
    test_reset_midword();
    test_load_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
